// File: rtl/spi_pkg.sv
// Shared types for the multi-mode SPI master: FSM states, latched mode bits, counter sizing.
// No logic; no latency; no backpressure.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int BIT_CNT_W      = $clog2(DEFAULT_DATA_W);

    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period tick generator: reloading down-counter armed when enable rises.
// First tick clk_div+1 cycles after enable rises, then every clk_div+1 cycles; no backpressure.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             sys_clk,
    input  logic             cpu_rst,
    input  logic             en,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tick
);

    logic             en_q, en_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        en_d  = en;
        cnt_d = cnt_q;
        if (en && !en_q) begin
            cnt_d = clk_div;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? clk_div : cnt_q - DIV_W'(1);
        end
    end

    assign tick = en && en_q && (cnt_q == '0);

    always_ff @(posedge sys_clk) begin
        if (!cpu_rst) begin
            en_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            en_q  <= en_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master, all CPOL/CPHA modes, MSB/LSB first, one-hot active-low chip selects.
// done lands 1+(2*DATA_W+2)*(clk_div+1) cycles after the start edge; start is ignored while busy.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 4
) (
    input  logic                      sys_clk,
    input  logic                      cpu_rst,
    input  logic                      start,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic [$clog2(NUM_CS):0]   cs_sel,
    input  logic [DIV_W-1:0]          clk_div,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic                      lsb_first,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso,
    output logic [NUM_CS-1:0]         spi_cs_n
);

    localparam int CNT_W = bit_cnt_w(DATA_W);
    localparam int CSW   = $clog2(NUM_CS) + 1;

    spi_state_e        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic              tick;
    logic              lead_edge;
    logic              last_bit;
    logic [NUM_CS-1:0] cs_dec;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                   input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .sys_clk (sys_clk),
        .cpu_rst (cpu_rst),
        .en      (state_q != IDLE),
        .clk_div (div_q),
        .tick    (tick)
    );

    // Out-of-range selects decode to no asserted line; the transfer still runs.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
        end
    end

    assign lead_edge = (sck_q == mode_q.cpol);
    assign last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            IDLE: begin
                sck_d = cpol;
                if (start) begin
                    mode_d.cpol      = cpol;
                    mode_d.cpha      = cpha;
                    mode_d.lsb_first = lsb_first;
                    div_d     = clk_div;
                    cs_n_d    = cs_dec;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    rx_sr_d   = '0;
                    state_d   = SETUP;
                    if (!cpha) begin
                        mosi_d  = head_bit(tx_data, lsb_first);
                        tx_sr_d = shift_out(tx_data, lsb_first);
                    end else begin
                        tx_sr_d = tx_data;
                    end
                end
            end
            SETUP: begin
                if (tick) state_d = XFER;
            end
            XFER: begin
                if (tick) begin
                    sck_d = ~sck_q;
                    if (lead_edge) begin
                        if (mode_q.cpha) begin
                            mosi_d  = head_bit(tx_sr_q, mode_q.lsb_first);
                            tx_sr_d = shift_out(tx_sr_q, mode_q.lsb_first);
                        end else begin
                            rx_sr_d = shift_in(rx_sr_q, spi_miso, mode_q.lsb_first);
                        end
                    end else begin
                        if (mode_q.cpha) begin
                            rx_sr_d = shift_in(rx_sr_q, spi_miso, mode_q.lsb_first);
                        end else if (!last_bit) begin
                            mosi_d  = head_bit(tx_sr_q, mode_q.lsb_first);
                            tx_sr_d = shift_out(tx_sr_q, mode_q.lsb_first);
                        end
                        if (last_bit) state_d = HOLD;
                        else          bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = IDLE;
                    cs_n_d    = '1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!cpu_rst) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            div_q     <= '0;
            cs_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: loopback and scripted-slave transfers across modes.
module tb_spi_master_multi;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;
    localparam int NUM_CS = 4;

    logic        sys_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  tx_data = '0;
    logic [2:0]  cs_sel = '0;
    logic [7:0]  clk_div = '0;
    logic        cpol = 1'b0;
    logic        cpha = 1'b0;
    logic        lsb_first = 1'b0;
    logic        busy, done;
    logic [7:0]  rx_data;
    logic        spi_sck, spi_mosi, spi_miso;
    logic [3:0]  spi_cs_n;

    logic        loop_en = 1'b1;
    logic        slave_bit = 1'b0;
    logic [7:0]  slave_word = '0;

    int          n_pass = 0;
    int          n_total = 0;
    int          lat, edges, cs_viol, busy_low, dones, extra;
    logic [7:0]  mlog;

    assign spi_miso = loop_en ? spi_mosi : slave_bit;

    always #5 sys_clk = ~sys_clk;

    spi_master_multi #(.DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_CS(NUM_CS)) dut (
        .sys_clk   (sys_clk),
        .cpu_rst   (cpu_rst),
        .start     (start),
        .tx_data   (tx_data),
        .cs_sel    (cs_sel),
        .clk_div   (clk_div),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Launch one transfer and watch it until done; lat is the edge count from the start edge.
    task automatic run_xfer(input logic [7:0] tx, input logic [2:0] cs, input logic [7:0] div,
                            input logic pol, input logic pha, input logic lsb,
                            input logic [3:0] exp_cs, input logic restart);
        logic sck_prev;
        logic lead;
        int   j;
        @(negedge sys_clk);
        tx_data = tx; cs_sel = cs; clk_div = div; cpol = pol; cpha = pha; lsb_first = lsb;
        @(negedge sys_clk);
        start = 1'b1;
        sck_prev = spi_sck;
        edges = 0; mlog = '0; cs_viol = 0; busy_low = 0; dones = 0; j = 0; lat = -1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge sys_clk);
            #1;
            if (restart && k == 4) begin
                start = 1'b1;
                tx_data = 8'hFF;
            end
            if (restart && k == 5) start = 1'b0;
            if (spi_sck !== sck_prev) begin
                edges++;
                lead = (spi_sck != pol);
                if (lead != pha) mlog = {mlog[6:0], spi_mosi};
                if (lead && !loop_en && j < 8) begin
                    slave_bit = lsb ? slave_word[j] : slave_word[7-j];
                    j++;
                end
                sck_prev = spi_sck;
            end
            if (done) begin
                dones++;
                lat = k;
                break;
            end
            if (spi_cs_n !== exp_cs) cs_viol++;
            if (busy !== 1'b1) busy_low++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge sys_clk);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_cs_n", spi_cs_n, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);
        cpu_rst = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Mode 0, fastest SCK, loopback
        run_xfer(8'hA5, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0, 4'b1101, 1'b0);
        check("m0_lat", lat, 19);
        check("m0_rx", rx_data, 8'hA5);
        check("m0_edges", edges, 16);
        check("m0_mosi", mlog, 8'hA5);
        check("m0_cs", cs_viol, 0);
        check("m0_busy", busy_low, 0);
        check("m0_sck_end", spi_sck, 0);
        check("m0_busy_done", busy, 0);

        // Mode 3, half-period 4
        @(negedge sys_clk);
        cpol = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("m3_sck_idle", spi_sck, 1);
        run_xfer(8'h3C, 3'd2, 8'd3, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b0);
        check("m3_lat", lat, 73);
        check("m3_rx", rx_data, 8'h3C);
        check("m3_edges", edges, 16);
        check("m3_mosi", mlog, 8'h3C);
        check("m3_sck_end", spi_sck, 1);

        // Mode 1, LSB first, scripted slave
        loop_en = 1'b0;
        slave_word = 8'h81;
        run_xfer(8'h01, 3'd0, 8'd1, 1'b0, 1'b1, 1'b1, 4'b1110, 1'b0);
        check("lsb_lat", lat, 37);
        check("lsb_mosi", mlog, 8'h80);
        check("lsb_rx", rx_data, 8'h81);
        check("lsb_edges", edges, 16);
        loop_en = 1'b1;

        // Second start while busy must be ignored
        run_xfer(8'h12, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b1);
        check("rs_dones", dones, 1);
        check("rs_lat", lat, 19);
        check("rs_mosi", mlog, 8'h12);
        check("rs_busy", busy_low, 0);
        check("rs_rx", rx_data, 8'h12);
        extra = 0;
        repeat (40) begin
            @(posedge sys_clk);
            #1 if (done) extra++;
        end
        check("rs_extra_done", extra, 0);
        check("rs_idle_busy", busy, 0);

        // Reset mid-transfer
        @(negedge sys_clk);
        tx_data = 8'h5A; cs_sel = 3'd3; clk_div = 8'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        @(negedge sys_clk);
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        repeat (8) @(posedge sys_clk);
        #1 cpu_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check("ab_cs_n", spi_cs_n, 4'hF);
        check("ab_busy", busy, 0);
        check("ab_sck", spi_sck, 0);
        check("ab_done", done, 0);
        check("ab_rx", rx_data, 0);
        extra = 0;
        @(negedge sys_clk);
        cpu_rst = 1'b1;
        repeat (5) begin
            @(posedge sys_clk);
            #1 if (done) extra++;
        end
        check("ab_no_done", extra, 0);
        run_xfer(8'hC3, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0);
        check("ab_new_lat", lat, 19);
        check("ab_new_rx", rx_data, 8'hC3);

        // Out-of-range chip select
        run_xfer(8'h69, 3'd4, 8'd0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
        check("cs4_cs", cs_viol, 0);
        check("cs4_edges", edges, 16);
        check("cs4_lat", lat, 19);
        check("cs4_rx", rx_data, 8'h69);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master peripheral for the topaz_geyser core. It generalises the core's single fixed-mode SPI port:
- configurable word width
- programmable SCK divider
- all four CPOL/CPHA modes
- MSB- or LSB-first shifting
- NUM_CS one-hot active-low chip selects

It sits on the core's peripheral side and is driven by a start/busy/done handshake from the CPU-facing register logic.

Parameters:
DATA_W, 8, bits per transfer (>=2)
DIV_W, 8, width of clk_div input
NUM_CS, 4, number of chip-select outputs (>=1)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
cpu_rst  in  1  synchronous, active-low reset
start  in  1  request transfer; sampled only in IDLE
tx_data  in  DATA_W  word to transmit, latched on accepted start
cs_sel  in  $clog2(NUM_CS)+1  target chip select, latched on start
clk_div  in  DIV_W  SCK half-period = clk_div+1 sys_clk cycles, latched on start
cpol  in  1  SCK idle level, latched on start
cpha  in  1  0: sample leading edge; 1: sample trailing edge; latched on start
lsb_first  in  1  shift order, latched on start
busy  out  1  high from cycle after accepted start until done cycle
done  out  1  one-cycle pulse; rx_data valid from this cycle
rx_data  out  DATA_W  received word, held until next done
spi_sck  out  1  serial clock
spi_mosi  out  1  serial data out
spi_miso  in  1  serial data in
spi_cs_n  out  NUM_CS  active-low chip selects

Behaviour:
- Reset values (cpu_rst==0 at a clock edge): spi_sck=0, spi_mosi=0, spi_cs_n=all 1, busy=0, done=0, rx_data=0, state=IDLE.
- Reset mid-transfer aborts: on the next edge, outputs take reset values, no done pulse, rx_data returns to 0.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> IDLE. Let H = clk_div+1, using the latched value.
- IDLE:
  - spi_sck registers the cpol input each cycle.
  - On start=1 at edge T: latch all config and tx_data, assert spi_cs_n[cs_sel]=0, go to SETUP.
  - busy=1 from T+1.
  - If cs_sel>=NUM_CS, no CS is asserted, but the transfer still runs.
- SETUP, lasts H cycles:
  - CPHA=0: first bit presented on spi_mosi at entry.
  - CPHA=1: spi_mosi holds its previous value until the first SCK edge.
- XFER, lasts 2*DATA_W*H cycles:
  - SCK toggles every H cycles, 2*DATA_W edges in total; SCK ends at cpol.
  - CPHA=0: sample spi_miso on each leading edge; shift out the next bit on each trailing edge, except after the last bit.
  - CPHA=1: shift out on each leading edge; sample on each trailing edge.
  - Bit order follows lsb_first for both TX and RX.
- HOLD, lasts H cycles; CS stays asserted. Next edge:
  - CS deasserted, rx_data updated, done=1, busy=0, state IDLE.
  - This is edge T+1+(2*DATA_W+2)*H.
- start while busy is ignored; no queuing.
- start in the done cycle is accepted, because the FSM is already in IDLE.
- clk_div=0 is legal: H=1, SCK = sys_clk/2.
- The bit counter runs 0..DATA_W-1 with no wrap beyond.
- The divider counter reloads to clk_div on every half-period tick.
- Config input changes during busy have no effect.

Decomposition:
- Package spi_pkg holds:
  - spi_state_e enum (IDLE, SETUP, XFER, HOLD)
  - spi_mode_t struct {cpol, cpha, lsb_first}
  - localparam for bit-counter width, $clog2(DATA_W)
- Sub-module spi_clk_gen holds the DIV_W down-counter.
  - Inputs: enable, latched clk_div.
  - Output: one-cycle half-period tick.
  - Reset to clk_div on enable rising.

Test Plan:
- Mode 0, clk_div=0, spi_miso looped to spi_mosi, tx_data=8'hA5, cs_sel=1, start at T:
  - cs_n=4'b1101 during the transfer.
  - done at T+19 with rx_data=8'hA5.
  - 16 SCK edges, SCK idle 0.
- Mode 3 (cpol=1, cpha=1), clk_div=3, tx_data=8'h3C, loopback:
  - SCK high at idle and at end.
  - Half-period is 4 cycles.
  - done at T+1+18*4=T+73; rx_data=8'h3C.
- lsb_first=1, mode 1, miso driven by a bench slave sending 8'h81 LSB-first, tx_data=8'h01:
  - MOSI bit stream 1,0,0,0,0,0,0,0.
  - rx_data=8'h81.
- start pulsed again at T+5 with tx_data=8'hFF, during a busy transfer of 8'h12:
  - Exactly one done.
  - MOSI carries 8'h12.
  - busy stays 1 throughout.
- cpu_rst=0 asserted at T+9 mid-transfer:
  - Next edge: cs_n=4'b1111, busy=0, sck=0, no done.
  - After release, a new start completes normally.
- cs_sel=4 with NUM_CS=4:
  - All cs_n stay 1.
  - SCK still toggles 16 times; done at T+19.
